// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding, widths and preset check for the countdown sequencer
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int PRESET_W = 16;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  // A preset is startable only when it is nonzero and its seconds-tens digit is 0..5.
  function automatic logic preset_ok(input logic [PRESET_W-1:0] p);
    return (p != '0) && (p[7:4] <= SEC_TENS_MAX);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to the one-second count tick, with hold and restart
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count while run is high, hold otherwise; restart zeroes the phase before a fresh run.
  always_ff @(posedge clk) begin
    if (clear || restart) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Tick marks the cycle in which the count wraps; the sequencer registers it into cnt_en.
  assign tick = run && (count == LAST);

endmodule

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - countdown control FSM: keypad preset, counter load/enable, interlock; TIMER_DONE_BEEP_EN adds beep
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int DIGITS   = 4
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        key_valid,
  input  logic [3:0]                  key_digit,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        cancel,
  input  logic                        door_closed,
  input  logic                        time_zero,
  output logic [DIGITS*DIGIT_W-1:0]   data_bcd,
  output logic                        cnt_loadn,
  output logic                        cnt_en,
  output logic                        running,
  output logic                        done,
  output logic [2:0]                  state
`ifdef TIMER_DONE_BEEP_EN
  ,
  output logic                        beep
`endif
);

  localparam int PW = DIGITS * DIGIT_W;

  state_t        st;
  logic [PW-1:0] preset;
  logic          tick;
  logic          presc_run;
  logic          presc_restart;
  logic          go;
  logic          key_ok;

  // The prescaler only advances on cycles where RUN is kept; any exit from RUN holds its phase.
  assign presc_run     = (st == ST_RUN) && !cancel && door_closed && !pause && !time_zero;
  assign presc_restart = (st == ST_LOAD);
  assign go            = start && door_closed && !pause && preset_ok(preset);
  assign key_ok        = key_valid && (key_digit <= DIGIT_MAX);
  assign state         = st;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .clear   (clear),
    .run     (presc_run),
    .restart (presc_restart),
    .tick    (tick)
  );

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (clear) begin
      st        <= ST_IDLE;
      preset    <= '0;
      data_bcd  <= '0;
      cnt_loadn <= 1'b1;
      cnt_en    <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_loadn <= 1'b1;
      cnt_en    <= 1'b0;
      if (cancel && (st != ST_IDLE)) begin
        // Abort: zero the preset and strobe zeros into the counters for one cycle.
        st        <= ST_IDLE;
        preset    <= '0;
        data_bcd  <= '0;
        cnt_loadn <= 1'b0;
        running   <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (cancel) begin
              preset <= '0;
            end else if (go) begin
              st        <= ST_LOAD;
              data_bcd  <= preset;
              cnt_loadn <= 1'b0;
            end else if (key_ok) begin
              preset <= {preset[PW-DIGIT_W-1:0], key_digit};
            end
          end
          ST_LOAD: begin
            st      <= ST_RUN;
            running <= 1'b1;
          end
          ST_RUN: begin
            if (!door_closed || pause) begin
              st      <= ST_PAUSED;
              running <= 1'b0;
            end else if (time_zero) begin
              st      <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              cnt_en <= tick;
            end
          end
          ST_PAUSED: begin
            if (start && door_closed && !pause) begin
              st      <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (key_valid) begin
              st     <= ST_IDLE;
              preset <= '0;
              done   <= 1'b0;
            end
          end
          default: begin
            st      <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TIMER_DONE_BEEP_EN
  localparam int            HALF = TICK_DIV / 2;
  localparam int            BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] HLAST = BW'(HALF - 1);

  logic [BW-1:0] beep_div;
  logic [2:0]    beep_half;
  logic          enter_done;

  assign enter_done = (st == ST_RUN) && !cancel && door_closed && !pause && time_zero;

  // Beep cadence: starts high on DONE entry, toggles each half period for three on/off cycles.
  always_ff @(posedge clk) begin
    if (clear) begin
      beep      <= 1'b0;
      beep_div  <= '0;
      beep_half <= '0;
    end else if (st != ST_DONE) begin
      beep      <= enter_done;
      beep_div  <= '0;
      beep_half <= '0;
    end else if (cancel || key_valid) begin
      beep <= 1'b0;
    end else if (beep_div == HLAST) begin
      beep_div <= '0;
      if (beep_half < 3'd5) begin
        beep      <= ~beep;
        beep_half <= beep_half + 3'd1;
      end else begin
        beep <= 1'b0;
      end
    end else begin
      beep_div <= beep_div + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - self-checking bench for timer_sequencer with a BCD counter datapath
module tb_timer_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        pause;
  logic        cancel;
  logic        door_closed;
  logic        time_zero;
  logic [15:0] data_bcd;
  logic        cnt_loadn;
  logic        cnt_en;
  logic        running;
  logic        done;
  logic [2:0]  state;

  logic [15:0] cnt_val;
  int total = 0;
  int bad = 0;
  int en_count = 0;
  int loadn_count = 0;

  timer_sequencer #(.TICK_DIV(TD), .DIGITS(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .pause       (pause),
    .cancel      (cancel),
    .door_closed (door_closed),
    .time_zero   (time_zero),
    .data_bcd    (data_bcd),
    .cnt_loadn   (cnt_loadn),
    .cnt_en      (cnt_en),
    .running     (running),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  // MM:SS countdown: convert to seconds, subtract one, convert back.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    int secs;
    secs = v[15:12] * 600 + v[11:8] * 60 + v[7:4] * 10 + v[3:0];
    if (secs > 0) secs = secs - 1;
    return {4'(secs / 600), 4'((secs / 60) % 10), 4'((secs % 60) / 10), 4'(secs % 10)};
  endfunction

  always @(posedge clk) begin
    if (clear) cnt_val <= 16'h0000;
    else if (!cnt_loadn) cnt_val <= data_bcd;
    else if (cnt_en) cnt_val <= bcd_dec(cnt_val);
  end
  assign time_zero = (cnt_val == 16'h0000);

  // Reference model: states by number, elapsed cycles in the current second.
  int          m_st = 0;
  int          m_elapsed = 0;
  logic [15:0] m_preset = 16'h0;
  logic [15:0] m_data = 16'h0;
  logic        m_loadn = 1'b1;
  logic        m_en = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    m_loadn = 1'b1;
    m_en = 1'b0;
    if (clear) begin
      m_valid = 1'b1;
      m_st = 0;
      m_preset = 16'h0;
      m_data = 16'h0;
      m_elapsed = 0;
    end else if (m_valid) begin
      if (cancel && m_st != 0) begin
        m_st = 0;
        m_preset = 16'h0;
        m_data = 16'h0;
        m_loadn = 1'b0;
      end else begin
        case (m_st)
          0: begin
            if (cancel) m_preset = 16'h0;
            else if (start && door_closed && !pause && m_preset != 0 && m_preset[7:4] <= 5) begin
              m_st = 1;
              m_data = m_preset;
              m_loadn = 1'b0;
            end else if (key_valid && key_digit <= 9)
              m_preset = (m_preset << 4) | {12'h0, key_digit};
          end
          1: begin
            m_st = 2;
            m_elapsed = 0;
          end
          2: begin
            if (!door_closed || pause) m_st = 3;
            else if (time_zero) m_st = 4;
            else begin
              m_elapsed = m_elapsed + 1;
              if (m_elapsed == TD) begin
                m_elapsed = 0;
                m_en = 1'b1;
              end
            end
          end
          3: if (start && door_closed && !pause) m_st = 2;
          4: if (key_valid) begin
            m_st = 0;
            m_preset = 16'h0;
          end
          default: m_st = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (state !== 3'(m_st) || data_bcd !== m_data || cnt_loadn !== m_loadn ||
          cnt_en !== m_en || running !== (m_st == 2) || done !== (m_st == 4)) begin
        bad++;
        $display("FAIL model t=%0t state=%0d exp %0d data=%h exp %h loadn=%b exp %b en=%b exp %b running=%b done=%b",
                 $time, state, m_st, data_bcd, m_data, cnt_loadn, m_loadn, cnt_en, m_en, running, done);
      end
      total++;
      if (!cnt_loadn && cnt_en) begin
        bad++;
        $display("FAIL load_en_excl t=%0t got loadn=0 en=1 required not both", $time);
      end
      if (cnt_en) en_count++;
      if (!cnt_loadn) loadn_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, {29'h0, state}, {29'h0, s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int c;
    int tz_c;
    int dn_c;
    bit seen0;

    clear = 1'b1; key_valid = 1'b0; key_digit = 4'h0; start = 1'b0;
    pause = 1'b0; cancel = 1'b0; door_closed = 1'b1;
    cyc(2);
    check("reset_state", {29'h0, state}, 32'd0);
    check("reset_loadn", {31'h0, cnt_loadn}, 32'd1);
    check("reset_en_run_done", {29'h0, cnt_en, running, done}, 32'd0);
    check("reset_data", {16'h0, data_bcd}, 32'h0);
    clear = 1'b0;

    // 01:30 load and first ticks
    key(4'd0); key(4'd1); key(4'd3); key(4'd0);
    loadn_count = 0;
    pulse_start();
    check("load_state", {29'h0, state}, 32'd1);
    check("load_strobe", {31'h0, cnt_loadn}, 32'd0);
    check("load_data", {16'h0, data_bcd}, 32'h0130);
    cyc(1);
    check("run_state", {29'h0, state}, 32'd2);
    check("counters_loaded", {16'h0, cnt_val}, 32'h0130);
    n = 0;
    while (!cnt_en && n < 12) begin cyc(1); n++; end
    check("first_en_latency", n, 32'd4);
    cyc(1);
    check("count_0129", {16'h0, cnt_val}, 32'h0129);
    n = 1;
    while (!cnt_en && n < 12) begin cyc(1); n++; end
    check("en_spacing", n, 32'd4);
    check("single_load_strobe", loadn_count, 32'd1);

    // cancel together with pause in RUN
    cyc(1);
    cancel = 1'b1; pause = 1'b1;
    cyc(1);
    cancel = 1'b0; pause = 1'b0;
    check("cancel_state", {29'h0, state}, 32'd0);
    check("cancel_strobe", {31'h0, cnt_loadn}, 32'd0);
    check("cancel_data", {16'h0, data_bcd}, 32'h0);
    cyc(1);
    check("cancel_strobe_end", {31'h0, cnt_loadn}, 32'd1);
    check("cancel_counters", {16'h0, cnt_val}, 32'h0);
    loadn_count = 0;
    pulse_start();
    cyc(3);
    check("zero_preset_idle", {29'h0, state}, 32'd0);
    check("zero_preset_noload", loadn_count, 32'd0);

    // 00:02 runs to completion
    key(4'd2);
    en_count = 0;
    pulse_start();
    c = 0; tz_c = -1; dn_c = -1; seen0 = 1'b0;
    while (c < 40 && dn_c < 0) begin
      if (!time_zero) seen0 = 1'b1;
      else if (seen0 && tz_c < 0) tz_c = c;
      if (done) dn_c = c;
      if (dn_c < 0) begin cyc(1); c++; end
    end
    check("done_seen", {31'h0, done}, 32'd1);
    check("done_after_tz", dn_c - tz_c, 32'd1);
    cyc(8);
    check("two_pulses", en_count, 32'd2);
    check("done_state", {29'h0, state}, 32'd4);
    key(4'd5);
    check("done_exit_state", {29'h0, state}, 32'd0);
    check("done_exit_done", {31'h0, done}, 32'd0);
    loadn_count = 0;
    pulse_start();
    cyc(2);
    check("exit_key_not_captured", loadn_count, 32'd0);

    // 00:75 is rejected
    key(4'd7); key(4'd5);
    loadn_count = 0;
    pulse_start();
    cyc(3);
    check("bad_sec_tens_idle", {29'h0, state}, 32'd0);
    check("bad_sec_tens_noload", loadn_count, 32'd0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;

    // door interlock with prescaler held at 2
    key(4'd1); key(4'd0);
    pulse_start();
    wait_state(3'd2, 5, "enter_run");
    cyc(2);
    door_closed = 1'b0;
    cyc(1);
    check("door_pause_state", {29'h0, state}, 32'd3);
    en_count = 0;
    cyc(10);
    check("no_en_paused", en_count, 32'd0);
    door_closed = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("resume_state", {29'h0, state}, 32'd2);
    n = 0;
    while (!cnt_en && n < 12) begin cyc(1); n++; end
    check("resume_latency", n, 32'd2);

    // clear in RUN
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_state", {29'h0, state}, 32'd0);
    check("clear_outputs", {28'h0, cnt_loadn, cnt_en, running, done}, 32'h8);
    check("clear_data", {16'h0, data_bcd}, 32'h0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
